// File: rtl/tick_slot_scheduler_pkg.sv
// Shared types, constants and round-robin helper for the tick-slot scheduler.
package tick_sched_pkg;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} sched_state_e;

   localparam int SLOT_W         = 8;
   localparam int DIV_DEFAULT_C  = 3;
   localparam int SLOT_DEFAULT_C = 187;
   localparam int RR_MAX         = 32;
   localparam int RR_IDX_W       = 5;

   // Rotate so the bit after 'last' sits at position 0, take the lowest set bit,
   // then rotate that position back to a requester index.
   function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int n, input int last);
      logic [RR_MAX-1:0] rot;
      int base, j, p;
      rot  = '0;
      p    = 0;
      base = last + 1;
      if (base >= n) base = 0;
      for (int i = 0; i < RR_MAX; i++) begin
         j = base + i;
         if (j >= n) j = j - n;
         if (i < n) rot[i] = req[j[RR_IDX_W-1:0]];
      end
      for (int i = RR_MAX - 1; i >= 0; i--)
         if (rot[i]) p = i;
      j = base + p;
      if (j >= n) j = j - n;
      return j;
   endfunction

endpackage

// File: rtl/tick_slot_scheduler_if.sv
// Config handshake plus request/grant bus between the scheduler and its pacers.
interface tick_slot_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 16
);
   import tick_sched_pkg::*;

   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [CNT_W-1:0]  cfg_div;
   logic [SLOT_W-1:0] cfg_slot;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              tick;
   logic              slot_start;
   logic              busy;

   modport master (
      output cfg_div, cfg_slot, cfg_valid, req,
      input  cfg_ready, gnt, gnt_id, tick, slot_start, busy
   );

   modport slave (
      input  cfg_div, cfg_slot, cfg_valid, req,
      output cfg_ready, gnt, gnt_id, tick, slot_start, busy
   );

endinterface

// File: rtl/tick_slot_scheduler_tick_gen.sv
// Free-running 0..div counter producing a one-cycle clock-enable tick.
module tick_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk2,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == div);

   // div only changes together with clr, so cnt never overshoots it
   always_ff @(posedge clk2 or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (clr || tick) cnt <= '0;
      else                  cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/tick_slot_scheduler.sv
// Shares tick-aligned slots among N_REQ requesters, round-robin, with early release.
module tick_slot_scheduler
   import tick_sched_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CNT_W        = 16,
   parameter int DIV_DEFAULT  = DIV_DEFAULT_C,
   parameter int SLOT_DEFAULT = SLOT_DEFAULT_C
) (
   input  logic                  clk2,
   input  logic                  rst,
   tick_slot_scheduler_if.slave  bus
);

   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   sched_state_e      state, state_n;
   logic [CNT_W-1:0]  div_q;
   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_cnt, slot_cnt_n;
   logic [ID_W-1:0]   last_id, last_id_n;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_n;
   logic [ID_W-1:0]   winner;
   logic [N_REQ-1:0]  gnt_q, gnt_n;
   logic              slot_start_q, slot_start_n;
   logic              grant_en;
   logic              tick;
   logic              cfg_acc;
   logic              any_req;
   logic [RR_MAX-1:0] req_pad;

   assign cfg_acc = bus.cfg_valid && (state == IDLE);
   assign any_req = |bus.req;

   tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
      .clk2 (clk2),
      .rst  (rst),
      .clr  (cfg_acc),
      .div  (div_q),
      .tick (tick)
   );

   always_ff @(posedge clk2 or posedge rst) begin
      if (rst) begin
         div_q  <= CNT_W'(DIV_DEFAULT);
         slot_q <= SLOT_W'(SLOT_DEFAULT);
      end else if (cfg_acc) begin
         div_q  <= bus.cfg_div;
         slot_q <= bus.cfg_slot;
      end
   end

   always_comb begin
      req_pad = '0;
      req_pad[N_REQ-1:0] = bus.req;
   end

   assign winner = ID_W'(rr_pick(req_pad, N_REQ, int'(last_id)));

   always_comb begin
      state_n      = state;
      slot_cnt_n   = slot_cnt;
      last_id_n    = last_id;
      gnt_id_n     = gnt_id_q;
      gnt_n        = gnt_q;
      slot_start_n = 1'b0;
      grant_en     = 1'b0;
      case (state)
         IDLE: begin
            if (tick && any_req) grant_en = 1'b1;
         end
         GRANT: begin
            // holder dropping its request wins over a coincident slot-end tick
            if (!bus.req[gnt_id_q]) begin
               state_n = IDLE;
               gnt_n   = '0;
            end else if (tick) begin
               if (slot_cnt == '0) begin
                  if (any_req) begin
                     grant_en = 1'b1;
                  end else begin
                     state_n = IDLE;
                     gnt_n   = '0;
                  end
               end else begin
                  slot_cnt_n = slot_cnt - SLOT_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (grant_en) begin
         state_n        = GRANT;
         slot_cnt_n     = slot_q;
         last_id_n      = winner;
         gnt_id_n       = winner;
         gnt_n          = '0;
         gnt_n[winner]  = 1'b1;
         slot_start_n   = 1'b1;
      end
   end

   always_ff @(posedge clk2 or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         slot_cnt     <= '0;
         last_id      <= ID_W'(N_REQ - 1);
         gnt_id_q     <= '0;
         gnt_q        <= '0;
         slot_start_q <= 1'b0;
      end else begin
         state        <= state_n;
         slot_cnt     <= slot_cnt_n;
         last_id      <= last_id_n;
         gnt_id_q     <= gnt_id_n;
         gnt_q        <= gnt_n;
         slot_start_q <= slot_start_n;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.gnt_id     = gnt_id_q;
   assign bus.tick       = tick;
   assign bus.slot_start = slot_start_q;
   assign bus.busy       = (state == GRANT);
   assign bus.cfg_ready  = (state == IDLE);

endmodule
